coeff_loader: RTL and testbench

//  Writer end of the Ram port that Filter reads (MemAddr/MemData/MemClk/MemWrite).

---
 rtl/coeff_loader.sv | 147 ++++++++++++++
 tb/tb_coeff_loader.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/coeff_loader.sv
// Coefficient RAM writer: buffers host byte writes in a small FIFO, requests the shared
// Ram bus from Filter, and drains each entry as a SETUP/STROBE/HOLD write cycle.
module coeff_loader #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] HostAddr,
    input  logic [DATA_W-1:0] HostData,
    input  logic              HostStrobe,
    output logic              HostReady,
    output logic              Overflow,
    output logic              BusReq,
    input  logic              BusGrant,
    output logic [ADDR_W-1:0] MemAddr,
    inout  wire  [DATA_W-1:0] MemData,
    output logic              MemClk,
    output logic              MemWrite,
    output logic [15:0]       WriteCount,
    output logic              Busy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = ADDR_W + DATA_W;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        SETUP  = 3'd2,
        STROBE = 3'd3,
        HOLD   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              host_ready_q, host_ready_d;
    logic              overflow_q, overflow_d;
    logic [15:0]       write_count_q, write_count_d;

    logic              full;
    logic              push;
    logic              pop;
    logic              mem_write;
    logic [ENT_W-1:0]  head;
    logic [ENT_W-1:0]  slot [DEPTH];

    assign full = (count_q == CNT_W'(DEPTH));
    assign push = HostStrobe && !full;
    assign pop  = (state_q == HOLD);
    assign head = slot[rd_ptr_q];

    // One register per FIFO slot; only the slot under the write pointer loads.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [ENT_W-1:0] entry_q, entry_d;

            always_comb begin
                entry_d = entry_q;
                if (push && (wr_ptr_q == PTR_W'(gi))) begin
                    entry_d = {HostAddr, HostData};
                end
            end

            always_ff @(posedge Clock) begin
                if (Reset) begin
                    entry_q <= '0;
                end else begin
                    entry_q <= entry_d;
                end
            end

            assign slot[gi] = entry_q;
        end
    endgenerate

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        write_count_d = write_count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d      = rd_ptr_q + PTR_W'(1);
            write_count_d = write_count_q + 16'd1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        host_ready_d = (count_d != CNT_W'(DEPTH));
        overflow_d   = HostStrobe && full;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (count_q != '0) state_d = REQ;
            REQ:     if (BusGrant) state_d = SETUP;
            SETUP:   state_d = BusGrant ? STROBE : REQ;
            STROBE:  state_d = HOLD;
            // A push landing during HOLD keeps the bus for one more write.
            HOLD:    state_d = (count_d != '0) ? SETUP : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            host_ready_q  <= 1'b1;
            overflow_q    <= 1'b0;
            write_count_q <= '0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            host_ready_q  <= host_ready_d;
            overflow_q    <= overflow_d;
            write_count_q <= write_count_d;
        end
    end

    // Bus outputs decode straight from the state register so a reset drops them at once.
    assign mem_write  = (state_q == SETUP) || (state_q == STROBE) || (state_q == HOLD);
    assign MemWrite   = mem_write;
    assign MemClk     = (state_q == STROBE);
    assign BusReq     = (state_q != IDLE);
    assign MemAddr    = mem_write ? head[ENT_W-1:DATA_W] : '0;
    assign MemData    = mem_write ? head[DATA_W-1:0] : 'z;
    assign HostReady  = host_ready_q;
    assign Overflow   = overflow_q;
    assign WriteCount = write_count_q;
    assign Busy       = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_coeff_loader.sv
// Directed bench for coeff_loader: reset, single write, bursts, overflow,
// grant loss during SETUP and reset in the middle of a burst.
module tb_coeff_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] host_addr;
    logic [7:0]  host_data;
    logic        host_strobe;
    logic        host_ready;
    logic        overflow;
    logic        bus_req;
    logic        bus_grant;
    logic [15:0] mem_addr;
    wire  [7:0]  mem_data;
    logic        mem_clk;
    logic        mem_write;
    logic [15:0] write_count;
    logic        busy;

    int compared   = 0;
    int mismatched = 0;
    int n_strobes  = 0;

    coeff_loader #(.DEPTH(4), .ADDR_W(16), .DATA_W(8)) dut (
        .Clock      (clk),
        .Reset      (rst),
        .HostAddr   (host_addr),
        .HostData   (host_data),
        .HostStrobe (host_strobe),
        .HostReady  (host_ready),
        .Overflow   (overflow),
        .BusReq     (bus_req),
        .BusGrant   (bus_grant),
        .MemAddr    (mem_addr),
        .MemData    (mem_data),
        .MemClk     (mem_clk),
        .MemWrite   (mem_write),
        .WriteCount (write_count),
        .Busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge mem_clk) n_strobes++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] a, input logic [7:0] d);
        host_addr   = a;
        host_data   = d;
        host_strobe = 1'b1;
        tick();
        host_strobe = 1'b0;
    endtask

    task automatic chk_write(input string tag, input logic [15:0] a, input logic [7:0] d);
        chk({tag, "_memclk"}, 32'(mem_clk), 32'd1);
        chk({tag, "_memwrite"}, 32'(mem_write), 32'd1);
        chk({tag, "_addr"}, 32'(mem_addr), 32'(a));
        chk({tag, "_data"}, 32'(mem_data), 32'(d));
    endtask

    initial begin
        rst         = 1'b1;
        host_addr   = '0;
        host_data   = '0;
        host_strobe = 1'b0;
        bus_grant   = 1'b0;

        // 1: reset state
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_hostready", 32'(host_ready), 32'd1);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_busreq", 32'(bus_req), 32'd0);
        chk("rst_memaddr", 32'(mem_addr), 32'd0);
        chk("rst_memclk", 32'(mem_clk), 32'd0);
        chk("rst_memwrite", 32'(mem_write), 32'd0);
        chk("rst_wcount", 32'(write_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        tick();

        // 2: single write with grant tied high; MemClk rises on the 4th cycle after the push
        bus_grant = 1'b1;
        push(16'h0010, 8'hA5);
        chk("t2_idle_busy", 32'(busy), 32'd1);
        chk("t2_idle_busreq", 32'(bus_req), 32'd0);
        tick();
        chk("t2_req_busreq", 32'(bus_req), 32'd1);
        chk("t2_req_memwrite", 32'(mem_write), 32'd0);
        tick();
        chk("t2_setup_memwrite", 32'(mem_write), 32'd1);
        chk("t2_setup_memclk", 32'(mem_clk), 32'd0);
        tick();
        chk_write("t2_strobe", 16'h0010, 8'hA5);
        tick();
        chk("t2_hold_memclk", 32'(mem_clk), 32'd0);
        tick();
        chk("t2_wcount", 32'(write_count), 32'd1);
        chk("t2_busreq_rel", 32'(bus_req), 32'd0);
        chk("t2_memwrite_rel", 32'(mem_write), 32'd0);
        chk("t2_memaddr_rel", 32'(mem_addr), 32'd0);
        chk("t2_busy", 32'(busy), 32'd0);
        chk("t2_strobes", 32'(n_strobes), 32'd1);

        // 3: four back-to-back entries, strobes 3 cycles apart
        push(16'h0000, 8'h11);
        push(16'h0001, 8'h22);
        push(16'h0002, 8'h33);
        push(16'h0003, 8'h44);
        chk("t3_full_ready", 32'(host_ready), 32'd0);
        chk_write("t3_w0", 16'h0000, 8'h11);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("t3_busreq_hold", 32'(bus_req), 32'd1);
            tick();
            chk("t3_busreq_setup", 32'(bus_req), 32'd1);
            tick();
            chk_write($sformatf("t3_w%0d", i), 16'(i), 8'(8'h11 * (i + 1)));
        end
        tick();
        tick();
        chk("t3_wcount", 32'(write_count), 32'd5);
        chk("t3_busreq_rel", 32'(bus_req), 32'd0);
        chk("t3_strobes", 32'(n_strobes), 32'd5);

        // 4: fill with no grant, then overflow
        bus_grant = 1'b0;
        for (int i = 0; i < 4; i++) push(16'h0100 + 16'(i), 8'hC0 + 8'(i));
        chk("t4_full_ready", 32'(host_ready), 32'd0);
        chk("t4_ovf_before", 32'(overflow), 32'd0);
        push(16'h01FF, 8'hEE);
        chk("t4_ovf_pulse", 32'(overflow), 32'd1);
        chk("t4_ready_still0", 32'(host_ready), 32'd0);
        tick();
        chk("t4_ovf_clear", 32'(overflow), 32'd0);
        chk("t4_req_wait", 32'(bus_req), 32'd1);
        chk("t4_no_write", 32'(mem_write), 32'd0);
        bus_grant = 1'b1;
        tick();
        tick();
        chk_write("t4_w0", 16'h0100, 8'hC0);
        for (int i = 1; i < 4; i++) begin
            repeat (3) tick();
            chk_write($sformatf("t4_w%0d", i), 16'h0100 + 16'(i), 8'hC0 + 8'(i));
        end
        tick();
        tick();
        chk("t4_idle_memwrite", 32'(mem_write), 32'd0);
        repeat (4) tick();
        chk("t4_wcount", 32'(write_count), 32'd9);
        chk("t4_strobes", 32'(n_strobes), 32'd9);

        // 5: grant withdrawn during SETUP
        push(16'h0200, 8'h5A);
        tick();
        tick();
        chk("t5_setup_memwrite", 32'(mem_write), 32'd1);
        bus_grant = 1'b0;
        tick();
        chk("t5_back_req_memwrite", 32'(mem_write), 32'd0);
        chk("t5_back_req_busreq", 32'(bus_req), 32'd1);
        chk("t5_back_req_memclk", 32'(mem_clk), 32'd0);
        tick();
        chk("t5_no_strobe", 32'(n_strobes), 32'd9);
        bus_grant = 1'b1;
        tick();
        tick();
        chk_write("t5_w", 16'h0200, 8'h5A);
        tick();
        tick();
        repeat (3) tick();
        chk("t5_wcount", 32'(write_count), 32'd10);
        chk("t5_strobes", 32'(n_strobes), 32'd10);

        // 6: reset during STROBE of a 3-entry burst
        push(16'h0300, 8'h71);
        push(16'h0301, 8'h72);
        push(16'h0302, 8'h73);
        tick();
        chk_write("t6_strobe", 16'h0300, 8'h71);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_memclk", 32'(mem_clk), 32'd0);
        chk("t6_memwrite", 32'(mem_write), 32'd0);
        chk("t6_wcount", 32'(write_count), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_ready", 32'(host_ready), 32'd1);
        chk("t6_busreq", 32'(bus_req), 32'd0);
        repeat (20) tick();
        chk("t6_strobes_after", 32'(n_strobes), 32'd11);
        chk("t6_wcount_after", 32'(write_count), 32'd0);
        chk("t6_busy_after", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
